// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide peripheral:
// register addresses, op encodings, CTRL/STATUS bit positions and core FSM states.
package muldiv_pkg;

  // Word addresses (bus bits [4:2]); 6 and 7 are reserved.
  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RES_HI = 3'd4;
  localparam logic [2:0] ADDR_RES_LO = 3'd5;

  // op[0] selects signed, op[1] selects divide.
  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_OP_LSB = 1;
  localparam int unsigned CTRL_IEN    = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_DZ   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFix
  } state_e;

endpackage

// File: rtl/peripheral_muldiv_seq_if.sv
// Peripheral bus bundle for the multiply/divide block.
//   d_in  : write data        cs   : chip select      addr : word address [4:2]
//   rd/wr : strobes (qualified by cs)
//   d_out : registered read data                      irq  : level interrupt
interface peripheral_muldiv_seq_if;
  logic [31:0] d_in;
  logic        cs;
  logic [2:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;
  logic        irq;

  modport master (output d_in, cs, addr, rd, wr, input d_out, irq);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out, irq);
endinterface

// File: rtl/muldiv_core.sv
// Radix-2 sequential multiply/divide engine, one result bit per clock.
// Sequence: IDLE -> LOAD (1) -> RUN (WIDTH) -> FIX (1) -> IDLE, independent of operands.
//   start      : begin an operation (only honoured in IDLE)
//   op         : operation, must stay stable while busy
//   a, b       : operands, sampled in LOAD
//   busy       : high from the cycle after start through FIX
//   done_pulse : high during FIX; res_hi/res_lo update at the end of that cycle
//   dz         : divide by zero detected for the current/last operation
//   res_hi/lo  : product high/low, or remainder/quotient
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_pulse,
  output logic             dz,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q;     // partial product high / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier being shifted out / dividend -> quotient
  logic [WIDTH-1:0] m_q;      // multiplicand magnitude / divisor magnitude
  logic             is_div_q;
  logic             neg_q;    // negate product or quotient in FIX
  logic             neg_r_q;  // negate remainder in FIX
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic               sub_ok;
  logic [WIDTH-1:0]   sub_res;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    a_neg   = op[0] & a[WIDTH-1];
    b_neg   = op[0] & b[WIDTH-1];
    a_abs   = a_neg ? -a : a;
    b_abs   = b_neg ? -b : b;
    add_sum = {1'b0, hi_q} + {1'b0, m_q};
    shl     = {hi_q, lo_q[WIDTH-1]};
    sub_ok  = shl >= {1'b0, m_q};
    // The true difference is below the divisor, so the low WIDTH bits suffice.
    sub_res  = shl[WIDTH-1:0] - m_q;
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_r_q ? -hi_q : hi_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
          end
        end
        StLoad: begin
          is_div_q <= op[1];
          cnt_q    <= '0;
          hi_q     <= '0;
          state_q  <= StRun;
          if (op[1]) begin
            lo_q    <= a_abs;
            m_q     <= b_abs;
            dz_q    <= (b == '0);
            // Divide by zero must yield an all-ones quotient regardless of signs.
            neg_q   <= (a_neg ^ b_neg) & (b != '0);
            neg_r_q <= a_neg;
          end else begin
            lo_q    <= b_abs;
            m_q     <= a_abs;
            neg_q   <= a_neg ^ b_neg;
            neg_r_q <= 1'b0;
          end
        end
        StRun: begin
          if (is_div_q) begin
            hi_q <= sub_ok ? sub_res : shl[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], sub_ok};
          end else if (lo_q[0]) begin
            {hi_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
          end else begin
            {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q <= StFix;
            done_q  <= 1'b1;
          end
        end
        StFix: begin
          if (is_div_q) begin
            res_hi_q <= rem_fix;
            res_lo_q <= quot_fix;
          end else begin
            {res_hi_q, res_lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign dz         = dz_q;
  assign res_hi     = res_hi_q;
  assign res_lo     = res_lo_q;

endmodule

// File: rtl/peripheral_muldiv_seq.sv
// Memory-mapped iterative multiply/divide peripheral.
// Holds the A/B/CTRL registers, sticky done/dz flags, the registered read mux and irq;
// the arithmetic lives in muldiv_core.
//   clk, rst : clock and synchronous active-high reset
//   bus      : peripheral bus (d_in, cs, addr, rd, wr -> d_out, irq)
module peripheral_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst,
  peripheral_muldiv_seq_if.slave bus
);

  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             ien_q;
  logic             done_q;
  logic             dz_q;
  logic [31:0]      d_out_q;

  logic             core_busy, core_done, core_dz;
  logic [WIDTH-1:0] core_hi, core_lo;

  logic        wr_en, start;
  logic [31:0] rd_data;
  logic        unused_d_in;

  // Bits above WIDTH are ignored by design.
  assign unused_d_in = ^bus.d_in;

  assign wr_en = bus.cs & bus.wr;
  // CTRL writes while busy are dropped entirely, so only an accepted start touches op/ien.
  assign start = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[CTRL_START] && !core_busy;

  muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .busy      (core_busy),
    .done_pulse(core_done),
    .dz        (core_dz),
    .res_hi    (core_hi),
    .res_lo    (core_lo)
  );

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      ADDR_A:      rd_data[WIDTH-1:0] = a_q;
      ADDR_B:      rd_data[WIDTH-1:0] = b_q;
      ADDR_STATUS: begin
        rd_data[STAT_BUSY] = core_busy;
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_DZ]   = dz_q;
      end
      ADDR_RES_HI: rd_data[WIDTH-1:0] = core_hi;
      ADDR_RES_LO: rd_data[WIDTH-1:0] = core_lo;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULU;
      ien_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      d_out_q <= '0;
    end else begin
      d_out_q <= (bus.cs && bus.rd) ? rd_data : '0;
      if (wr_en && bus.addr == ADDR_A) a_q <= bus.d_in[WIDTH-1:0];
      if (wr_en && bus.addr == ADDR_B) b_q <= bus.d_in[WIDTH-1:0];
      if (start) begin
        op_q   <= op_e'(bus.d_in[CTRL_OP_LSB +: 2]);
        ien_q  <= bus.d_in[CTRL_IEN];
        done_q <= 1'b0;
        dz_q   <= 1'b0;
      end else begin
        if (core_done) done_q <= 1'b1;
        if (core_dz)   dz_q   <= 1'b1;
      end
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.irq   = done_q & ien_q;

endmodule

// File: tb/tb_peripheral_muldiv_seq.sv
// Self-checking bench: a WIDTH=32 and a WIDTH=8 instance driven over their buses.
module tb_peripheral_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst, rst8;
  always #5 clk = ~clk;

  peripheral_muldiv_seq_if bus32 ();
  peripheral_muldiv_seq_if bus8 ();

  peripheral_muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst),  .bus(bus32));
  peripheral_muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8), .bus(bus8));

  typedef struct {
    op_e         op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  task automatic drive(input int u, input logic c, input logic r, input logic w,
                       input logic [2:0] a, input logic [31:0] d);
    if (u == 0) begin
      bus32.cs = c; bus32.rd = r; bus32.wr = w; bus32.addr = a; bus32.d_in = d;
    end else begin
      bus8.cs = c; bus8.rd = r; bus8.wr = w; bus8.addr = a; bus8.d_in = d;
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input int u, input logic [2:0] a, input logic [31:0] d);
    drive(u, 1'b1, 1'b0, 1'b1, a, d);
    @(posedge clk); #1;
    drive(u, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic bus_read(input int u, input logic [2:0] a, output logic [31:0] d);
    drive(u, 1'b1, 1'b1, 1'b0, a, 32'd0);
    @(posedge clk); #1;
    d = (u == 0) ? bus32.d_out : bus8.d_out;
    drive(u, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  function automatic logic irq_of(input int u);
    return (u == 0) ? bus32.irq : bus8.irq;
  endfunction

  task automatic start_op(input int u, input op_e op, input logic ien,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz;
    sb_q.push_back(e);
    bus_write(u, ADDR_CTRL, {28'd0, ien, op, 1'b1});
  endtask

  // Poll STATUS until busy drops, then pop the scoreboard and compare.
  task automatic finish_op(input int u, input string tag, input int exp_lat);
    logic [31:0] st, d;
    int   lat = 0;
    bit   ok = 0;
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      bus_read(u, ADDR_STATUS, st);
      if (!st[STAT_BUSY]) begin
        ok = 1;
        break;
      end
      lat++;
    end
    check({tag, " completion"}, 32'(ok), 32'd1);
    if (exp_lat >= 0) check({tag, " busy cycles"}, lat, exp_lat);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " done"}, 32'(st[STAT_DONE]), 32'd1);
      check({tag, " dz"}, 32'(st[STAT_DZ]), 32'(e.dz));
      bus_read(u, ADDR_RES_HI, d);
      check({tag, " RES_HI"}, d, e.hi);
      bus_read(u, ADDR_RES_LO, d);
      check({tag, " RES_LO"}, d, e.lo);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;

    vecs[0] = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{OP_MULS, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{OP_DIVS, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{OP_DIVU, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[4] = '{OP_DIVS, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[5] = '{OP_DIVU, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};
    vecs[6] = '{OP_MULS, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
    vecs[7] = '{OP_DIVS, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8] = '{OP_DIVS, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[9] = '{OP_MULU, 32'h12345678, 32'd0,        32'd0,        32'd0,        1'b0};

    rst = 1'b1; rst8 = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst8 = 1'b0;

    // Reset state
    bus_read(0, ADDR_STATUS, d); check("reset STATUS", d, 32'd0);
    bus_read(0, ADDR_RES_LO, d); check("reset RES_LO", d, 32'd0);
    bus_read(0, ADDR_A, d);      check("reset A", d, 32'd0);
    check("reset irq", 32'(irq_of(0)), 32'd0);

    // Table-driven vectors on the 32-bit instance
    for (int i = 0; i < 10; i++) begin
      bus_write(0, ADDR_A, vecs[i].a);
      bus_write(0, ADDR_B, vecs[i].b);
      start_op(0, vecs[i].op, 1'b0, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      finish_op(0, $sformatf("vec%0d", i), 34);
      check($sformatf("vec%0d irq", i), 32'(irq_of(0)), 32'd0);
    end
    bus_read(0, 3'd6, d); check("reserved read", d, 32'd0);

    // Writes while busy: A changes, CTRL ignored; op and ien keep their values.
    bus_write(0, ADDR_A, 32'd3);
    bus_write(0, ADDR_B, 32'd5);
    start_op(0, OP_MULU, 1'b1, 32'd0, 32'd15, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    bus_write(0, ADDR_A, 32'd9);
    bus_write(0, ADDR_CTRL, {28'd0, 1'b0, OP_DIVU, 1'b1});
    finish_op(0, "busy-ignore", -1);
    check("busy-ignore irq", 32'(irq_of(0)), 32'd1);
    bus_read(0, ADDR_A, d); check("busy-ignore A", d, 32'd9);
    start_op(0, OP_MULU, 1'b1, 32'd0, 32'd45, 1'b0);
    check("restart irq", 32'(irq_of(0)), 32'd0);
    bus_read(0, ADDR_STATUS, d); check("restart STATUS", d, 32'd1);
    finish_op(0, "restart", -1);
    check("restart irq done", 32'(irq_of(0)), 32'd1);

    // 8-bit instance
    bus_write(1, ADDR_A, 32'hFF);
    bus_write(1, ADDR_B, 32'hFF);
    start_op(1, OP_MULU, 1'b1, 32'hFE, 32'h01, 1'b0);
    finish_op(1, "w8 mulu", 10);
    check("w8 irq", 32'(irq_of(1)), 32'd1);
    bus_write(1, ADDR_A, 32'hFFFFFFF9);
    bus_read(1, ADDR_A, d); check("w8 A truncated", d, 32'hF9);
    bus_write(1, ADDR_B, 32'd2);
    start_op(1, OP_DIVS, 1'b0, 32'hFF, 32'hFD, 1'b0);
    finish_op(1, "w8 divs", 10);

    // Reset in the middle of RUN
    bus_write(1, ADDR_A, 32'hFF);
    bus_write(1, ADDR_B, 32'hFF);
    start_op(1, OP_MULU, 1'b1, 32'hFE, 32'h01, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    sb_q.delete();
    bus_read(1, ADDR_STATUS, d); check("w8 rst STATUS", d, 32'd0);
    check("w8 rst irq", 32'(irq_of(1)), 32'd0);
    bus_read(1, ADDR_RES_HI, d); check("w8 rst RES_HI", d, 32'd0);
    bus_read(1, ADDR_RES_LO, d); check("w8 rst RES_LO", d, 32'd0);
    bus_read(1, ADDR_A, d);      check("w8 rst A", d, 32'd0);

    // Still works after reset
    bus_write(1, ADDR_A, 32'h0C);
    bus_write(1, ADDR_B, 32'h0B);
    start_op(1, OP_MULU, 1'b0, 32'h00, 32'h84, 1'b0);
    finish_op(1, "w8 post-rst", 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peripheral_muldiv_seq.md
Name: peripheral_muldiv_seq

Overview:
- Memory-mapped iterative multiply/divide peripheral on the core's peripheral bus.
- Generalises the existing multiplier peripheral: parametrised operand width, signed and unsigned modes, divide with remainder, status flags and an optional interrupt.
- The bus wrapper decodes registers. A radix-2 sequential core computes one bit per clock.

Parameters:
WIDTH, 32, operand width in bits; legal range 4..32. Only d_in[WIDTH-1:0] is used. Results are zero-extended to 32 bits on read.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous to clk, active-high
d_in  in  32  bus write data
cs  in  1  peripheral chip select
addr  in  3  word address, bus bits [4:2]
rd  in  1  read strobe, qualified by cs
wr  in  1  write strobe, qualified by cs
d_out  out  32  registered read data
irq  out  1  level interrupt: done & ien

Behaviour:
- Register map (addr):
  - 0 = A (R/W), dividend or multiplicand.
  - 1 = B (R/W), divisor or multiplier.
  - 2 = CTRL (W): bit0 start, bits[2:1] op, bit3 ien.
  - 3 = STATUS (R): bit0 busy, bit1 done, bit2 dz.
  - 4 = RES_HI (R): product high word, or remainder.
  - 5 = RES_LO (R): product low word, or quotient.
  - 6, 7 = reserved; reads return 0, writes are ignored.
- op encoding: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- Reads: d_out is registered with 1-cycle latency. It updates on every posedge: the selected register when cs&rd, else 0.
- Writes: take effect on the posedge where cs&wr.
- A and B may be written at any time. Operands are snapshotted in LOAD, so writes during busy do not affect the running operation.
- CTRL write with start=1 while busy=0:
  - latch op and ien;
  - clear done and dz;
  - go to LOAD.
- CTRL write while busy=1: completely ignored (op, ien and start).
- FSM states:
  - IDLE: wait for start.
  - LOAD (1 cycle): take absolute values for signed ops, record result signs, set dz if the op is a divide and B=0.
  - RUN (exactly WIDTH cycles, counter 0..WIDTH-1): shift-add for multiply, restoring shift-subtract for divide.
  - FIX (1 cycle): apply two's-complement sign correction, write RES_HI/RES_LO, set done.
  - FIX returns to IDLE.
- Latency: start accepted at edge 0 → done=1 and results valid after edge WIDTH+2. busy=1 for exactly WIDTH+2 cycles. Latency is fixed for all ops and operand values.
- Multiply: 2*WIDTH-bit product; high half to RES_HI, low half to RES_LO. MULS treats both operands as signed.
- Divide truncates toward zero. For DIVS, the remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones (WIDTH bits), remainder = A, dz=1. Latency is unchanged.
- DIVS overflow (A = -2^(WIDTH-1), B = -1): quotient = -2^(WIDTH-1), remainder = 0, dz=0.
- done and dz are sticky until the next accepted start or rst. Reading STATUS does not clear them.
- irq = done & ien, combinational from registered flags.
- rst, including mid-operation, forces:
  - state IDLE;
  - A, B, RES_HI, RES_LO, op, ien, done, dz, counter, d_out all 0;
  - irq=0.
- Simultaneous read of RES_* in the FIX cycle returns the old value. A read on the following cycle returns the new value.

Decomposition:
- Package muldiv_pkg holds:
  - address constants ADDR_A..ADDR_RES_LO;
  - op encodings OP_MULU/OP_MULS/OP_DIVU/OP_DIVS;
  - CTRL/STATUS bit positions;
  - FSM state encoding (IDLE, LOAD, RUN, FIX).
- Sub-module muldiv_core:
  - ports: clk, rst, start, op, a, b, busy, done_pulse, dz, res_hi, res_lo;
  - contains the FSM, counter and datapath.
- peripheral_muldiv_seq contains the address decode, A/B/CTRL registers, sticky flags, read mux and irq.

Test Plan:
- WIDTH=32, MULU, A=0xFFFFFFFF, B=0xFFFFFFFF → RES_HI=0xFFFFFFFE, RES_LO=0x00000001. busy for exactly 34 cycles, then done=1.
- WIDTH=32, MULS, A=0xFFFFFFFD (-3), B=7 → RES_HI=0xFFFFFFFF, RES_LO=0xFFFFFFEB (-21).
- DIVS, A=0xFFFFFFF9 (-7), B=2 → RES_LO=0xFFFFFFFD (-3), RES_HI=0xFFFFFFFF (-1).
- DIVU, A=100, B=0 → RES_LO=0xFFFFFFFF, RES_HI=100, dz=1, done=1. Then DIVS 0x80000000 / 0xFFFFFFFF → RES_LO=0x80000000, RES_HI=0, dz=0.
- Start MULU 3*5 with ien=1:
  - at RUN cycle 10, write A=9 and CTRL start with op=DIVU → ignored; result stays 15, op and ien unchanged;
  - irq=1 at completion;
  - a new start clears done and irq.
- WIDTH=8, MULU 0xFF*0xFF → RES_HI=0xFE, RES_LO=0x01, done after 10 cycles. Repeat and assert rst mid-RUN → STATUS=0, RES_*=0, irq=0 on the next read.
